// File: rtl/regfile_wb_queue_pkg.sv
// Shared register-file definitions: widths, the zero register and the writeback entry type.
// Used by the writeback queue, the RegisterFile bench and the hazard logic.
package regfile_pkg;

  localparam int REG_W    = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_W-1:0]  dst_reg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_zero_reg(input logic [REG_W-1:0] r);
    return r == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Writeback request handshake from the execute/memory stages into the writeback queue.
interface regfile_wb_queue_if;

  logic                         req_valid;
  logic                         req_ready;
  logic [regfile_pkg::REG_W-1:0]  req_reg;
  logic [regfile_pkg::DATA_W-1:0] req_data;

  modport master (output req_valid, output req_reg, output req_data, input req_ready);
  modport slave  (input req_valid, input req_reg, input req_data, output req_ready);

endinterface

// File: rtl/regfile_wb_queue_fwd_match.sv
// Forwarding match for one RF read port: entries arrive oldest-first, so the last hit wins
// and the youngest pending write to the register is returned.
module wb_fwd_match
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wb_entry_t [DEPTH-1:0] entries,
  input  logic      [DEPTH-1:0] occupied,
  input  logic      [REG_W-1:0] src_reg,
  output logic                  hit,
  output logic     [DATA_W-1:0] data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (!is_zero_reg(src_reg)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (occupied[i] && entries[i].dst_reg == src_reg) begin
          hit  = 1'b1;
          data = entries[i].data;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file: buffers requests, drains one per cycle
// onto the RF write port and forwards pending data to both RF read ports.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_wb_queue_if.slave         req,
  input  logic                      wb_en,
  output logic [REG_W-1:0]          DstReg,
  output logic                      WriteReg,
  output logic [DATA_W-1:0]         DstData,
  input  logic [REG_W-1:0]          SrcReg1,
  input  logic [REG_W-1:0]          SrcReg2,
  output logic                      fwd1_hit,
  output logic [DATA_W-1:0]         fwd1_data,
  output logic                      fwd2_hit,
  output logic [DATA_W-1:0]         fwd2_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [COUNT_W-1:0]    count_q, count_d;

  logic full;
  logic ready;
  logic enq;
  logic deq;

  wb_entry_t [DEPTH-1:0] age_entries;
  logic      [DEPTH-1:0] age_occupied;

  // Ready comes only from registered occupancy; R0 requests handshake but are dropped.
  always_comb begin
    full  = (count_q == COUNT_W'(DEPTH));
    ready = ~full;
    empty = (count_q == '0);
    deq   = ~empty & wb_en;
    enq   = req.req_valid & ready & ~is_zero_reg(req.req_reg);

    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (enq) begin
      mem_d[wr_ptr_q] = '{dst_reg: req.req_reg, data: req.req_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (enq && !deq) begin
      count_d = count_q + COUNT_W'(1);
    end else if (!enq && deq) begin
      count_d = count_q - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Present the queue oldest-first so the matchers need no knowledge of the pointers.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entries[i]  = mem_q[rd_ptr_q + PTR_W'(i)];
      age_occupied[i] = (COUNT_W'(i) < count_q);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .entries  (age_entries),
    .occupied (age_occupied),
    .src_reg  (SrcReg1),
    .hit      (fwd1_hit),
    .data     (fwd1_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
    .entries  (age_entries),
    .occupied (age_occupied),
    .src_reg  (SrcReg2),
    .hit      (fwd2_hit),
    .data     (fwd2_data)
  );

  assign req.req_ready = ready;
  assign WriteReg      = deq;
  assign DstReg        = mem_q[rd_ptr_q].dst_reg;
  assign DstData       = mem_q[rd_ptr_q].data;
  assign count         = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based model of the writeback rules.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        wb_en;
  logic [3:0]  DstReg;
  logic        WriteReg;
  logic [15:0] DstData;
  logic [3:0]  SrcReg1;
  logic [3:0]  SrcReg2;
  logic        fwd1_hit;
  logic [15:0] fwd1_data;
  logic        fwd2_hit;
  logic [15:0] fwd2_data;
  logic [2:0]  count;
  logic        empty;

  int vectors     = 0;
  int miscompares = 0;

  ent_t mq[$];

  regfile_wb_queue_if rq ();

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (rq),
    .wb_en     (wb_en),
    .DstReg    (DstReg),
    .WriteReg  (WriteReg),
    .DstData   (DstData),
    .SrcReg1   (SrcReg1),
    .SrcReg2   (SrcReg2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelFwd(input logic [3:0] s, output logic h, output logic [15:0] d);
    h = 1'b0;
    d = '0;
    if (s != 4'd0) begin
      foreach (mq[i]) begin
        if (mq[i].r == s) begin
          h = 1'b1;
          d = mq[i].d;
        end
      end
    end
  endfunction

  task automatic applyStimulus(input logic v, input logic [3:0] r, input logic [15:0] d,
                               input logic we, input logic [3:0] s1, input logic [3:0] s2);
    rq.req_valid = v;
    rq.req_reg   = r;
    rq.req_data  = d;
    wb_en        = we;
    SrcReg1      = s1;
    SrcReg2      = s2;
  endtask

  task automatic checkOutput();
    int          n;
    logic        exp_wr;
    logic        h;
    logic [15:0] d;
    n      = mq.size();
    exp_wr = (n > 0) && wb_en;
    chk("count", 32'(count), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("req_ready", 32'(rq.req_ready), 32'(n < DEPTH));
    chk("WriteReg", 32'(WriteReg), 32'(exp_wr));
    if (exp_wr) begin
      chk("DstReg", 32'(DstReg), 32'(mq[0].r));
      chk("DstData", 32'(DstData), 32'(mq[0].d));
    end
    modelFwd(SrcReg1, h, d);
    chk("fwd1_hit", 32'(fwd1_hit), 32'(h));
    chk("fwd1_data", 32'(fwd1_data), 32'(d));
    modelFwd(SrcReg2, h, d);
    chk("fwd2_hit", 32'(fwd2_hit), 32'(h));
    chk("fwd2_data", 32'(fwd2_data), 32'(d));
  endtask

  task automatic modelEdge();
    int   n;
    logic acc;
    ent_t e;
    n   = mq.size();
    acc = rq.req_valid && (n < DEPTH);
    if (n > 0 && wb_en) void'(mq.pop_front());
    if (acc && rq.req_reg != 4'd0) begin
      e.r = rq.req_reg;
      e.d = rq.req_data;
      mq.push_back(e);
    end
  endtask

  task automatic settle();
    #1;
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst) modelEdge();
    @(negedge clk);
  endtask

  task automatic cycle(input logic v, input logic [3:0] r, input logic [15:0] d,
                       input logic we, input logic [3:0] s1, input logic [3:0] s2);
    applyStimulus(v, r, d, we, s1, s2);
    settle();
    advance();
  endtask

  task automatic doReset();
    rst = 1'b1;
    mq.delete();
    settle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    doReset();

    // Reset asserted mid-cycle with three entries queued
    for (int i = 1; i <= 3; i++) cycle(1'b1, 4'(i + 8), 16'(16'h0A00 + i), 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 4'd10);
    settle();
    chk("mid_count_before", 32'(count), 32'd3);
    #1;
    rst = 1'b1;
    mq.delete();
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_WriteReg", 32'(WriteReg), 32'd0);
    chk("rst_req_ready", 32'(rq.req_ready), 32'd1);
    chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single write R5 = 0x1234
    cycle(1'b1, 4'd5, 16'h1234, 1'b1, 4'd0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 4'd0);
    settle();
    chk("single_WriteReg", 32'(WriteReg), 32'd1);
    chk("single_DstReg", 32'(DstReg), 32'd5);
    chk("single_DstData", 32'(DstData), 32'h1234);
    chk("single_fwd1", 32'(fwd1_data), 32'h1234);
    advance();
    settle();
    chk("single_drained", 32'(count), 32'd0);

    // Backpressure: four queued with wb_en low, fifth held until space opens
    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 16'(16'h0100 + i), 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 4'd5, 16'h0105, 1'b0, 4'd0, 4'd0);
    settle();
    chk("bp_full_ready", 32'(rq.req_ready), 32'd0);
    chk("bp_full_count", 32'(count), 32'd4);
    advance();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k < 2, 4'd5, 16'h0105, 1'b1, 4'd0, 4'd0);
      settle();
      chk("bp_order_reg", 32'(DstReg), 32'(k + 1));
      chk("bp_order_data", 32'(DstData), 32'(16'h0101 + k));
      advance();
    end

    // Forwarding returns the younger of two writes to R3
    cycle(1'b1, 4'd3, 16'h00AA, 1'b0, 4'd0, 4'd0);
    cycle(1'b1, 4'd3, 16'h00BB, 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd3, 4'd7);
    settle();
    chk("fwd_hit1", 32'(fwd1_hit), 32'd1);
    chk("fwd_data1", 32'(fwd1_data), 32'h00BB);
    chk("fwd_hit2", 32'(fwd2_hit), 32'd0);
    chk("fwd_data2", 32'(fwd2_data), 32'd0);
    advance();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd0);
    settle();
    chk("fwd_first_issued", 32'(DstData), 32'h00AA);
    advance();
    cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 4'd0);

    // R0 request is accepted and dropped
    applyStimulus(1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 4'd0);
    settle();
    chk("r0_ready", 32'(rq.req_ready), 32'd1);
    advance();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 4'd0);
    settle();
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_WriteReg", 32'(WriteReg), 32'd0);
    chk("r0_fwd1_hit", 32'(fwd1_hit), 32'd0);
    advance();

    // Full with a dequeue: no enqueue that cycle, then steady enq+deq across pointer wrap
    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 16'(16'h0200 + i), 1'b0, 4'd0, 4'd0);
    applyStimulus(1'b1, 4'd9, 16'h0909, 1'b1, 4'd9, 4'd1);
    settle();
    chk("full_deq_count", 32'(count), 32'd4);
    chk("full_deq_WriteReg", 32'(WriteReg), 32'd1);
    advance();
    settle();
    chk("full_deq_after", 32'(count), 32'd3);
    advance();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 4'($urandom_range(1, 15)), 16'($urandom), 1'b1,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      settle();
      chk("wrap_count", 32'(count), 32'd3);
      advance();
    end
    for (int k = 0; k < 4; k++) cycle(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 4'd0);

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom),
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
        doReset();
      end else begin
        cycle($urandom_range(0, 9) < 6, 4'($urandom_range(0, 7)), 16'($urandom),
              $urandom_range(0, 9) < 5, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
